kronos_dmem_responder: RTL

//  Target end of the Kronos data bus: serves kronos_lsu load/store requests

---
 rtl/kronos_dmem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/kronos_dmem_responder.sv
// -----------------------------------------------------------------------------
// kronos_dmem_responder
//
// Purpose:
//   Target end of the Kronos data bus. It serves load/store requests from the
//   LSU out of an internal word-organized memory array. The block supports
//   byte-masked stores and a fixed, parameterizable number of wait states. It
//   returns a single-cycle acknowledge and flags out-of-range accesses.
//
// Ports:
//   clk           in   1   core clock, all state on rising edge
//   rst           in   1   asynchronous, active-high reset
//   data_addr     in   32  byte address; [1:0] ignored (word-aligned bus)
//   data_wr_data  in   32  store data, lane-aligned
//   data_mask     in   4   byte-lane write enables (bit i -> bits 8i+7:8i)
//   data_wr_en    in   1   1 = store, 0 = load
//   data_req      in   1   request valid; held with its fields until ack
//   data_rd_data  out  32  load data, valid while data_ack=1, else holds
//   data_ack      out  1   one-cycle completion pulse
//   data_err      out  1   out-of-range flag, valid while data_ack=1
//
// Parameters:
//   WORDS        memory depth in 32-bit words (power of 2, >= 4)
//   WAIT_CYCLES  extra cycles between request accept and ack (0..15)
// -----------------------------------------------------------------------------
module kronos_dmem_responder #(
    parameter int WORDS       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic        data_err
);

    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        oob_q,   oob_d;
    logic [31:0] rd_q,    rd_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;

    // Memory contents are deliberately not reset.
    logic [31:0] mem [WORDS];

    logic [29:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             in_range;
    logic             accept;
    logic             mem_we;
    logic             unused_addr_bits;

    assign word_idx = data_addr[31:2];
    assign mem_idx  = data_addr[IDX_W+1:2];
    // The range check uses every upper address bit. An address past the
    // array must never alias back onto a low word.
    assign in_range = ({2'b00, word_idx} < 32'(WORDS));
    assign accept   = (state_q == S_IDLE) && data_req;
    assign mem_we   = accept && data_wr_en && in_range;

    // Byte offset bits are meaningless on this word-aligned bus.
    assign unused_addr_bits = ^data_addr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oob_d   = oob_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    oob_d = !in_range;
                    // This is the pre-write word, so a store also reports the old contents.
                    rd_d  = in_range ? mem[mem_idx] : 32'h0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // The bus is not sampled here. A held request is taken on the next IDLE edge.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The outputs are registered from the next state, so no combinational path runs from req.
        ack_d = (state_d == S_RESP);
        err_d = ack_d && oob_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            oob_q   <= 1'b0;
            rd_q    <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oob_q   <= oob_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // A store commits on its accept edge. Reset held at that edge suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (data_mask[i]) begin
                    mem[mem_idx][8*i +: 8] <= data_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign data_rd_data = rd_q;
    assign data_ack     = ack_q;
    assign data_err     = err_q;

endmodule
